// File: rtl/mod_reduce_issuer.sv
// Issues one modular-reduction job at a time to an external reducer and queues
// the results in a small in-order FIFO, flagging timeouts and suspicious results.
module mod_reduce_issuer #(
    parameter int DATA_WIDTH     = 48,
    parameter int Q_WIDTH        = 23,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [Q_WIDTH-1:0]    in_q,
    output logic                  red_start,
    output logic [DATA_WIDTH-1:0] red_data_in,
    output logic [Q_WIDTH-1:0]    red_q,
    input  logic                  red_done,
    input  logic [Q_WIDTH-1:0]    red_data_out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [Q_WIDTH-1:0]    out_data,
    output logic [2:0]            err
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES) + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t                  state_r;
    logic [TMO_W-1:0]        wait_cnt_r;
    logic                    red_start_r;
    logic [DATA_WIDTH-1:0]   red_data_in_r;
    logic [Q_WIDTH-1:0]      red_q_r;
    logic [2:0]              err_r;
    logic [Q_WIDTH-1:0]      fifo_mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_r;
    logic [PTR_W-1:0]        rd_ptr_r;
    logic [CNT_W-1:0]        count_r;

    logic                    fifo_full_s;
    logic                    accept_s;
    logic                    push_s;
    logic                    pop_s;

    // Only one job is ever in flight, so checking room at acceptance guarantees push space.
    assign fifo_full_s = (count_r == CNT_W'(FIFO_DEPTH));
    assign in_ready    = (state_r == ST_IDLE) && !fifo_full_s;
    assign accept_s    = in_valid && in_ready;
    assign push_s      = (state_r == ST_WAIT) && red_done;
    assign out_valid   = (count_r != {CNT_W{1'b0}});
    assign pop_s       = out_valid && out_ready;
    assign out_data    = fifo_mem_r[rd_ptr_r];

    assign red_start   = red_start_r;
    assign red_data_in = red_data_in_r;
    assign red_q       = red_q_r;
    assign err         = err_r;

    // Control FSM: operand latch, start pulse, WAIT timeout and sticky error flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            wait_cnt_r    <= {TMO_W{1'b0}};
            red_start_r   <= 1'b0;
            red_data_in_r <= {DATA_WIDTH{1'b0}};
            red_q_r       <= {Q_WIDTH{1'b0}};
            err_r         <= 3'b000;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        red_data_in_r <= in_data;
                        red_q_r       <= in_q;
                        if (in_q == {Q_WIDTH{1'b0}}) begin
                            err_r[2] <= 1'b1;
                        end else begin
                            red_start_r <= 1'b1;
                            state_r     <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    red_start_r <= 1'b0;
                    wait_cnt_r  <= {TMO_W{1'b0}};
                    state_r     <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (red_done) begin
                        if (red_data_out >= red_q_r) begin
                            err_r[1] <= 1'b1;
                        end
                        state_r <= ST_IDLE;
                    end else if (wait_cnt_r == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                        err_r[0] <= 1'b1;
                        state_r  <= ST_IDLE;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + TMO_W'(1);
                    end
                end
                default: begin
                    red_start_r <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    // Result FIFO storage and pointers; pointers wrap naturally at a power-of-two depth.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem_r[i] <= {Q_WIDTH{1'b0}};
            end
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
        end else begin
            if (push_s) begin
                fifo_mem_r[wr_ptr_r] <= red_data_out;
                wr_ptr_r             <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
        end
    end

    // Occupancy count; simultaneous push and pop leave it unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= {CNT_W{1'b0}};
        end else begin
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: tb/tb_mod_reduce_issuer.sv
// Directed bench for mod_reduce_issuer with a behavioural reducer of programmable latency.
module tb_mod_reduce_issuer;

    localparam int DW = 48;
    localparam int QW = 23;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic [QW-1:0] in_q = '0;
    logic          red_start;
    logic [DW-1:0] red_data_in;
    logic [QW-1:0] red_q;
    logic          red_done = 1'b0;
    logic [QW-1:0] red_data_out = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [QW-1:0] out_data;
    logic [2:0]    err;

    int total = 0;
    int bad = 0;

    // reducer model controls
    logic          model_en = 1'b1;
    int            model_delay = 2;
    logic          model_ovr = 1'b0;
    logic [QW-1:0] model_val = '0;
    logic          model_busy = 1'b0;
    int            model_cnt = 0;
    logic [QW-1:0] model_res = '0;

    logic [DW-1:0] ops_d [6];
    logic [QW-1:0] ops_q [6];
    logic [QW-1:0] got   [6];
    int            hold_acc;
    logic          hold_ir;
    logic          hold_ov;

    mod_reduce_issuer #(
        .DATA_WIDTH(DW), .Q_WIDTH(QW), .FIFO_DEPTH(4), .TIMEOUT_CYCLES(64)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_q(in_q),
        .red_start(red_start), .red_data_in(red_data_in), .red_q(red_q),
        .red_done(red_done), .red_data_out(red_data_out),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .err(err)
    );

    always #5 clk = ~clk;

    // Behavioural reducer: red_done is high in WAIT cycle number model_delay.
    always @(posedge clk) begin
        logic [QW-1:0] r;
        red_done <= 1'b0;
        if (model_busy) begin
            if (model_cnt <= 1) begin
                red_done     <= 1'b1;
                red_data_out <= model_res;
                model_busy   <= 1'b0;
            end else begin
                model_cnt <= model_cnt - 1;
            end
        end else if (red_start && model_en) begin
            r = model_ovr ? model_val : QW'(red_data_in % DW'(red_q));
            model_res <= r;
            if (model_delay <= 1) begin
                red_done     <= 1'b1;
                red_data_out <= r;
            end else begin
                model_busy <= 1'b1;
                model_cnt  <= model_delay - 1;
            end
        end
    end

    task automatic do_reset;
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0 || err !== 3'b000 || red_start !== 1'b0) begin
            bad++;
            $display("FAIL reset_outs: out_valid=%b err=%b red_start=%b, want 0 000 0", out_valid, err, red_start);
        end
        total++;
        if (red_data_in !== 48'd0 || red_q !== 23'd0) begin
            bad++;
            $display("FAIL reset_red: red_data_in=%0d red_q=%0d, want 0 0", red_data_in, red_q);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_basic;
        int starts;
        do_reset();
        model_delay = 5;
        model_ovr = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; in_data = 48'd65536; in_q = 23'd3329;
        @(negedge clk);
        in_valid = 1'b0;
        starts = 0;
        for (int cyc = 0; cyc < 40 && !out_valid; cyc++) begin
            if (red_start) starts++;
            total++;
            if (red_data_in !== 48'd65536 || red_q !== 23'd3329) begin
                bad++;
                $display("FAIL basic_hold: red_data_in=%0d red_q=%0d want 65536 3329", red_data_in, red_q);
            end
            @(negedge clk);
        end
        total++;
        if (out_valid !== 1'b1) begin
            bad++;
            $display("FAIL basic_timeout: out_valid=%b want 1", out_valid);
        end
        total++;
        if (starts !== 1) begin
            bad++;
            $display("FAIL basic_start_pulses: got %0d want 1", starts);
        end
        total++;
        if (out_data !== 23'd2285 || err !== 3'b000) begin
            bad++;
            $display("FAIL basic_result: out_data=%0d err=%b want 2285 000", out_data, err);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL basic_pop: out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_min_latency;
        do_reset();
        model_delay = 1;
        @(negedge clk);
        in_valid = 1'b1; in_data = 48'd10000; in_q = 23'd4591;
        @(negedge clk);
        in_valid = 1'b0;
        total++;
        if (red_start !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL lat_issue: red_start=%b out_valid=%b want 1 0", red_start, out_valid);
        end
        @(negedge clk);
        total++;
        if (red_start !== 1'b0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL lat_wait: red_start=%b out_valid=%b want 0 0", red_start, out_valid);
        end
        @(negedge clk);
        total++;
        if (out_valid !== 1'b1 || out_data !== 23'd818) begin
            bad++;
            $display("FAIL lat_out: out_valid=%b out_data=%0d want 1 818", out_valid, out_data);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    // Streams n operands; out_ready stays low until cycle 'hold'.
    task automatic run_ops(input int n, input int hold);
        int acc, rcv, cyc;
        logic fire_in, fire_out;
        acc = 0; rcv = 0; fire_in = 1'b0; fire_out = 1'b0;
        for (cyc = 0; cyc < 400 && rcv < n; cyc++) begin
            @(negedge clk);
            if (fire_in) acc++;
            if (cyc == hold) begin
                hold_acc = acc; hold_ir = in_ready; hold_ov = out_valid;
            end
            out_ready = (cyc >= hold);
            in_valid = (acc < n);
            if (acc < n) begin
                in_data = ops_d[acc]; in_q = ops_q[acc];
            end
            fire_in = in_valid && in_ready;
            fire_out = out_valid && out_ready;
            if (fire_out) begin
                got[rcv] = out_data;
                rcv++;
            end
        end
        total++;
        if (rcv !== n) begin
            bad++;
            $display("FAIL stream_timeout: received %0d want %0d", rcv, n);
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b0;
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL stream_drained: out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_back_to_back;
        do_reset();
        model_delay = 2;
        ops_d[0] = 48'd16777216; ops_q[0] = 23'd8380417;
        ops_d[1] = 48'd10000;    ops_q[1] = 23'd4591;
        got[0] = '0; got[1] = '0;
        run_ops(2, 0);
        total++;
        if (got[0] !== 23'd16382 || got[1] !== 23'd818) begin
            bad++;
            $display("FAIL b2b_order: got %0d,%0d want 16382,818", got[0], got[1]);
        end
    endtask

    task automatic test_fifo_full;
        logic [QW-1:0] exp [6];
        do_reset();
        model_delay = 2;
        ops_d[0] = 48'd65536;    ops_q[0] = 23'd3329;    exp[0] = 23'd2285;
        ops_d[1] = 48'd16777216; ops_q[1] = 23'd8380417; exp[1] = 23'd16382;
        ops_d[2] = 48'd10000;    ops_q[2] = 23'd4591;    exp[2] = 23'd818;
        ops_d[3] = 48'd100;      ops_q[3] = 23'd7;       exp[3] = 23'd2;
        ops_d[4] = 48'd1000000;  ops_q[4] = 23'd3329;    exp[4] = 23'd1300;
        ops_d[5] = 48'd8380416;  ops_q[5] = 23'd8380417; exp[5] = 23'd8380416;
        for (int i = 0; i < 6; i++) got[i] = '0;
        run_ops(6, 40);
        total++;
        if (hold_acc !== 4 || hold_ir !== 1'b0 || hold_ov !== 1'b1) begin
            bad++;
            $display("FAIL full_stall: accepted=%0d in_ready=%b out_valid=%b want 4 0 1", hold_acc, hold_ir, hold_ov);
        end
        for (int i = 0; i < 6; i++) begin
            total++;
            if (got[i] !== exp[i]) begin
                bad++;
                $display("FAIL full_order[%0d]: got %0d want %0d", i, got[i], exp[i]);
            end
        end
    endtask

    task automatic test_timeout;
        do_reset();
        model_en = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; in_data = 48'd12345; in_q = 23'd3329;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (64) @(negedge clk);
        total++;
        if (err !== 3'b000 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL timeout_early: err=%b in_ready=%b want 000 0", err, in_ready);
        end
        @(negedge clk);
        total++;
        if (err !== 3'b001 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL timeout_abort: err=%b in_ready=%b out_valid=%b want 001 1 0", err, in_ready, out_valid);
        end
        model_en = 1'b1;
    endtask

    task automatic test_errors;
        int starts;
        do_reset();
        model_delay = 2;
        model_ovr = 1'b1;
        model_val = 23'd3329;
        @(negedge clk);
        in_valid = 1'b1; in_data = 48'd9999; in_q = 23'd3329;
        @(negedge clk);
        in_valid = 1'b0;
        for (int cyc = 0; cyc < 20 && !out_valid; cyc++) @(negedge clk);
        total++;
        if (out_valid !== 1'b1 || out_data !== 23'd3329 || err !== 3'b010) begin
            bad++;
            $display("FAIL err_range: out_valid=%b out_data=%0d err=%b want 1 3329 010", out_valid, out_data, err);
        end
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        out_ready = 1'b0;
        total++;
        if (err !== 3'b010) begin
            bad++;
            $display("FAIL err_sticky: err=%b want 010", err);
        end
        model_ovr = 1'b0;
        do_reset();
        @(negedge clk);
        in_valid = 1'b1; in_data = 48'd500; in_q = 23'd0;
        starts = 0;
        @(negedge clk);
        in_valid = 1'b0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            if (red_start) starts++;
            @(negedge clk);
        end
        total++;
        if (starts !== 0 || err !== 3'b100 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL err_qzero: starts=%0d err=%b out_valid=%b in_ready=%b want 0 100 0 1", starts, err, out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid_wait;
        do_reset();
        model_delay = 5;
        @(negedge clk);
        in_valid = 1'b1; in_data = 48'd65536; in_q = 23'd3329;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            @(negedge clk);
            total++;
            if (out_valid !== 1'b0 || err !== 3'b000 || red_start !== 1'b0 ||
                red_q !== 23'd0 || red_data_in !== 48'd0 || in_ready !== 1'b1) begin
                bad++;
                $display("FAIL rst_wait[%0d]: out_valid=%b err=%b red_start=%b red_q=%0d red_data_in=%0d in_ready=%b want 0 000 0 0 0 1",
                         cyc, out_valid, err, red_start, red_q, red_data_in, in_ready);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_min_latency();
        test_back_to_back();
        test_fifo_full();
        test_timeout();
        test_errors();
        test_reset_mid_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mod_reduce_issuer.md
MOD_REDUCE_ISSUER -- requirements
Module: mod_reduce_issuer

Interface
REQ-001 Parameter DATA_WIDTH, default 48, width of the unreduced operand.
REQ-002 Parameter Q_WIDTH, default 23, width of the modulus and the result.
REQ-003 Parameter FIFO_DEPTH, default 4, result FIFO entries; power of two, at least 2.
REQ-004 Parameter TIMEOUT_CYCLES, default 64, maximum WAIT cycles before abort.
REQ-005 Port clk  input  1  sole clock; all state changes on the rising edge.
REQ-006 Port rst  input  1  asynchronous, active-high reset.
REQ-007 Port in_valid  input  1  upstream operand valid.
REQ-008 Port in_ready  output  1  operand accepted when in_valid && in_ready.
REQ-009 Port in_data  input  DATA_WIDTH  operand to reduce.
REQ-010 Port in_q  input  Q_WIDTH  modulus for this operand.
REQ-011 Port red_start  output  1  one-cycle start pulse to the reducer.
REQ-012 Port red_data_in  output  DATA_WIDTH  operand to the reducer.
REQ-013 Port red_q  output  Q_WIDTH  modulus to the reducer.
REQ-014 Port red_done  input  1  reducer result valid.
REQ-015 Port red_data_out  input  Q_WIDTH  reducer result.
REQ-016 Port out_valid  output  1  result FIFO non-empty.
REQ-017 Port out_ready  input  1  downstream pops the result when out_valid && out_ready.
REQ-018 Port out_data  output  Q_WIDTH  FIFO head result.
REQ-019 Port err  output  3  sticky flags: [0] timeout, [1] result >= q, [2] q == 0.

Function
REQ-020 The FSM SHALL have the states IDLE, ISSUE and WAIT.
REQ-021 IDLE: in_ready SHALL be 1 only while the FIFO count < FIFO_DEPTH; on acceptance, in_data and in_q SHALL be latched and the state SHALL go to ISSUE.
REQ-022 A latched q == 0 SHALL set err[2], push nothing, and return to IDLE instead of ISSUE.
REQ-023 ISSUE: red_start SHALL be 1 for exactly this one cycle, then the state SHALL go to WAIT.
REQ-024 red_data_in and red_q SHALL hold the latched values stable from ISSUE through the end of WAIT.
REQ-025 red_done SHALL be ignored in IDLE and ISSUE.
REQ-026 WAIT: on red_done == 1, red_data_out SHALL be pushed into the FIFO on the same edge and the state SHALL go to IDLE.
REQ-027 If the captured result >= the latched q, err[1] SHALL be set and the result SHALL still be pushed.
REQ-028 A WAIT cycle counter SHALL clear on entry to WAIT.
REQ-029 If TIMEOUT_CYCLES WAIT cycles elapse without red_done, err[0] SHALL be set, the operation SHALL be dropped with no push, and the state SHALL go to IDLE.
REQ-030 Only one operation SHALL be outstanding, so a push never finds the FIFO full.
REQ-031 A simultaneous push and pop SHALL leave the count unchanged and preserve order.
REQ-032 Pointers SHALL wrap modulo FIFO_DEPTH; out_data SHALL be the head entry combinationally; results SHALL leave in acceptance order.
REQ-033 Minimum latency SHALL be 3 cycles: accept edge, ISSUE, and the first WAIT cycle with red_done, giving out_valid on the following cycle.
REQ-034 err bits SHALL be cleared only by rst.

Reset
REQ-035 rst SHALL force state IDLE, FIFO empty, counters 0, err 0, red_start 0, red_data_in 0, red_q 0 and out_valid 0.
REQ-036 in_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-037 A reset during WAIT SHALL abort the operation; a red_done arriving after the reset SHALL be ignored and nothing SHALL be pushed.

Verification
REQ-038 in_data=65536, in_q=3329, reducer model returns after 5 cycles -> red_start single pulse, out_data=2285, err=0.
REQ-039 Back-to-back 16777216/8380417 then 10000/4591 with out_ready=1 -> outputs 16382 then 818, in order.
REQ-040 out_ready=0, six operands offered -> four results stored, in_ready low after the 4th push; raising out_ready drains 4 in order, then remaining operands proceed.
REQ-041 Reducer never asserts red_done, TIMEOUT_CYCLES=64 -> after 64 WAIT cycles err[0]=1, no out_valid, in_ready=1.
REQ-042 Model returns 3329 for q=3329 -> err[1]=1 and 3329 appears on out_data; separately in_q=0 -> err[2]=1, red_start never pulses.
REQ-043 rst asserted mid-WAIT, model asserts red_done 2 cycles later -> FIFO stays empty and all outputs hold reset values.
